mm_ram_periph: RTL and testbench

Testbench memory subsystem for the CV32E40P core. It provides a dual-port RAM, with one instruction port and one data port, both using OBI-style req/gnt/rvalid handshakes. It also decodes a small set of memory-mapped pseudo peripherals on the data port: stdout, test status, exit, timer interrupt and debug request. It sits beside the core in the top-level TB wrapper and drives the pass/fail/exit outputs.

---
 rtl/mm_ram_pkg.sv | 40 ++++
 rtl/dp_ram.sv | 58 +++++
 rtl/mm_ram_periph.sv | 152 +++++++++++++++
 tb/tb_mm_ram_periph.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_ram_pkg.sv
// Address map and status constants shared by the memory subsystem.
// Peripheral decode helper used on the data port.
package mm_ram_pkg;

  localparam logic [31:0] PRINT_ADDR      = 32'h1000_0000;
  localparam logic [31:0] STATUS_ADDR     = 32'h2000_0000;
  localparam logic [31:0] EXIT_ADDR       = 32'h2000_0004;
  localparam logic [31:0] TIMER_MASK_ADDR = 32'h1500_0000;
  localparam logic [31:0] TIMER_CNT_ADDR  = 32'h1500_0004;
  localparam logic [31:0] DEBUG_ADDR      = 32'h1500_0008;

  localparam logic [31:0] TEST_PASS_VALUE = 32'd123456789;
  localparam logic [31:0] TEST_FAIL_VALUE = 32'd1;

  typedef enum logic [2:0] {
    PERIPH_NONE,
    PERIPH_PRINT,
    PERIPH_STATUS,
    PERIPH_EXIT,
    PERIPH_TMASK,
    PERIPH_TCNT,
    PERIPH_DEBUG
  } periph_sel_e;

  function automatic periph_sel_e decode_periph(input logic [31:0] addr);
    periph_sel_e sel;
    sel = PERIPH_NONE;
    case (addr)
      PRINT_ADDR:      sel = PERIPH_PRINT;
      STATUS_ADDR:     sel = PERIPH_STATUS;
      EXIT_ADDR:       sel = PERIPH_EXIT;
      TIMER_MASK_ADDR: sel = PERIPH_TMASK;
      TIMER_CNT_ADDR:  sel = PERIPH_TCNT;
      DEBUG_ADDR:      sel = PERIPH_DEBUG;
      default:         sel = PERIPH_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Byte-enabled dual-port RAM: port A is a wide read-only fetch port,
// port B is a 32-bit read/write port. Both reads are registered.
module dp_ram #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned RDATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    a_en_i,
  input  logic [ADDR_WIDTH-3:0]   a_word_i,
  output logic [RDATA_WIDTH-1:0]  a_rdata_o,
  input  logic                    b_en_i,
  input  logic                    b_we_i,
  input  logic [ADDR_WIDTH-3:0]   b_word_i,
  input  logic [3:0]              b_be_i,
  input  logic [31:0]             b_wdata_i,
  output logic [31:0]             b_rdata_o
);

  localparam int unsigned WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam int unsigned LANES = RDATA_WIDTH / 32;

  logic [31:0]            r_mem [WORDS];
  logic [RDATA_WIDTH-1:0] r_a_rdata;
  logic [31:0]            r_b_rdata;
  logic [ADDR_WIDTH-3:0]  w_a_base;

  // Wide fetches return the naturally aligned line, lowest word in lane 0.
  assign w_a_base = a_word_i & ~((ADDR_WIDTH-2)'(LANES - 1));

  // Contents are deliberately not reset; the environment preloads them.
  always_ff @(posedge clk_i) begin
    if (b_en_i && b_we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (b_be_i[i]) r_mem[b_word_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
      end
    end
  end

  // Reads sample the pre-write contents, so a same-cycle fetch sees old data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (a_en_i) begin
        for (int i = 0; i < LANES; i++) begin
          r_a_rdata[i*32 +: 32] <= r_mem[w_a_base | (ADDR_WIDTH-2)'(i)];
        end
      end
      if (b_en_i && !b_we_i) r_b_rdata <= r_mem[b_word_i];
    end
  end

  assign a_rdata_o = r_a_rdata;
  assign b_rdata_o = r_b_rdata;

endmodule

// File: rtl/mm_ram_periph.sv
// Core-side memory subsystem: dual-port RAM with zero-wait OBI handshakes
// plus memory-mapped status, exit, timer-interrupt and debug-request registers.
module mm_ram_periph
  import mm_ram_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH    = 20,
  parameter int unsigned INSTR_RDATA_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [31:0]                  dm_halt_addr_i,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
  output logic                         instr_rvalid_o,
  output logic                         instr_gnt_o,
  input  logic                         data_req_i,
  input  logic [31:0]                  data_addr_i,
  input  logic                         data_we_i,
  input  logic [3:0]                   data_be_i,
  input  logic [31:0]                  data_wdata_i,
  output logic [31:0]                  data_rdata_o,
  output logic                         data_rvalid_o,
  output logic                         data_gnt_o,
  input  logic [4:0]                   irq_id_i,
  input  logic                         irq_ack_i,
  output logic [31:0]                  irq_o,
  output logic                         debug_req_o,
  input  logic [31:0]                  pc_core_id_i,
  output logic                         tests_passed_o,
  output logic                         tests_failed_o,
  output logic                         exit_valid_o,
  output logic [31:0]                  exit_value_o
);

  logic                         w_data_in_ram;
  logic                         w_data_wr;
  logic                         w_ram_en_b;
  logic                         w_tcnt_load;
  logic                         w_timer_expire;
  periph_sel_e                  w_periph;
  logic [31:0]                  w_ack_mask;
  logic [31:0]                  w_irq_next;
  logic [31:0]                  w_ram_rdata_b;
  logic [INSTR_RDATA_WIDTH-1:0] w_ram_rdata_a;
  logic                         w_unused;

  logic        r_instr_rvalid;
  logic        r_data_rvalid;
  logic        r_data_ram_rd;
  logic        r_debug_req;
  logic        r_passed;
  logic        r_failed;
  logic        r_exit_valid;
  logic [31:0] r_exit_value;
  logic [31:0] r_irq;
  logic [31:0] r_timer_cnt;
  logic [31:0] r_timer_mask;

  assign w_data_in_ram = (data_addr_i >> RAM_ADDR_WIDTH) == 32'd0;
  assign w_data_wr     = data_req_i & data_we_i;
  assign w_ram_en_b    = data_req_i & w_data_in_ram;
  assign w_periph      = decode_periph(data_addr_i);

  dp_ram #(
    .ADDR_WIDTH  (RAM_ADDR_WIDTH),
    .RDATA_WIDTH (INSTR_RDATA_WIDTH)
  ) u_dp_ram (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .a_en_i    (instr_req_i),
    .a_word_i  (instr_addr_i[RAM_ADDR_WIDTH-1:2]),
    .a_rdata_o (w_ram_rdata_a),
    .b_en_i    (w_ram_en_b),
    .b_we_i    (data_we_i),
    .b_word_i  (data_addr_i[RAM_ADDR_WIDTH-1:2]),
    .b_be_i    (data_be_i),
    .b_wdata_i (data_wdata_i),
    .b_rdata_o (w_ram_rdata_b)
  );

  // A load in the same cycle as the 1 -> 0 step pre-empts the decrement,
  // so no interrupt is raised in that cycle.
  assign w_tcnt_load    = w_data_wr && (w_periph == PERIPH_TCNT);
  assign w_timer_expire = (r_timer_cnt == 32'd1) && !w_tcnt_load;

  always_comb begin
    w_ack_mask = '0;
    if (irq_ack_i) w_ack_mask = 32'd1 << irq_id_i;
    w_irq_next = r_irq & ~w_ack_mask;
    if (w_timer_expire) w_irq_next = w_irq_next | r_timer_mask;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      r_data_ram_rd  <= 1'b0;
      r_debug_req    <= 1'b0;
      r_passed       <= 1'b0;
      r_failed       <= 1'b0;
      r_exit_valid   <= 1'b0;
      r_exit_value   <= '0;
      r_irq          <= '0;
      r_timer_cnt    <= '0;
      r_timer_mask   <= '0;
    end else begin
      r_instr_rvalid <= instr_req_i;
      r_data_rvalid  <= data_req_i;
      r_data_ram_rd  <= data_req_i & ~data_we_i & w_data_in_ram;
      r_irq          <= w_irq_next;

      if (w_tcnt_load)             r_timer_cnt <= data_wdata_i;
      else if (r_timer_cnt != '0)  r_timer_cnt <= r_timer_cnt - 32'd1;

      // Stdout writes are accepted with no register effect; the simulation
      // wrapper observes the data port to render characters.
      if (w_data_wr) begin
        case (w_periph)
          PERIPH_STATUS: begin
            if (data_wdata_i == TEST_PASS_VALUE) r_passed <= 1'b1;
            if (data_wdata_i == TEST_FAIL_VALUE) r_failed <= 1'b1;
          end
          PERIPH_EXIT: begin
            r_exit_valid <= 1'b1;
            r_exit_value <= data_wdata_i;
          end
          PERIPH_TMASK: r_timer_mask <= data_wdata_i;
          PERIPH_DEBUG: r_debug_req  <= data_wdata_i[0];
          default: ;
        endcase
      end
    end
  end

  assign instr_gnt_o    = instr_req_i;
  assign data_gnt_o     = data_req_i;
  assign instr_rvalid_o = r_instr_rvalid;
  assign data_rvalid_o  = r_data_rvalid;
  assign instr_rdata_o  = w_ram_rdata_a;
  assign data_rdata_o   = r_data_ram_rd ? w_ram_rdata_b : 32'd0;
  assign irq_o          = r_irq;
  assign debug_req_o    = r_debug_req;
  assign tests_passed_o = r_passed;
  assign tests_failed_o = r_failed;
  assign exit_valid_o   = r_exit_valid;
  assign exit_value_o   = r_exit_value;

  assign w_unused = ^{dm_halt_addr_i, pc_core_id_i,
                      instr_addr_i[31:RAM_ADDR_WIDTH], instr_addr_i[1:0]};

endmodule

// File: tb/tb_mm_ram_periph.sv
// Randomised bench for mm_ram_periph against a word-array behavioural model,
// with directed literal checks for the memory, status, timer and reset paths.
module tb_mm_ram_periph;

  localparam int unsigned AW        = 20;
  localparam int unsigned IW        = 128;
  localparam int unsigned RAM_BYTES = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [31:0]   dm_halt_addr_i;
  logic          instr_req_i;
  logic [31:0]   instr_addr_i;
  logic [IW-1:0] instr_rdata_o;
  logic          instr_rvalid_o;
  logic          instr_gnt_o;
  logic          data_req_i;
  logic [31:0]   data_addr_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_wdata_i;
  logic [31:0]   data_rdata_o;
  logic          data_rvalid_o;
  logic          data_gnt_o;
  logic [4:0]    irq_id_i;
  logic          irq_ack_i;
  logic [31:0]   irq_o;
  logic          debug_req_o;
  logic [31:0]   pc_core_id_i;
  logic          tests_passed_o;
  logic          tests_failed_o;
  logic          exit_valid_o;
  logic [31:0]   exit_value_o;

  mm_ram_periph #(.RAM_ADDR_WIDTH(AW), .INSTR_RDATA_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dm_halt_addr_i(dm_halt_addr_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_gnt_o(instr_gnt_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .data_rvalid_o(data_rvalid_o), .data_gnt_o(data_gnt_o),
    .irq_id_i(irq_id_i), .irq_ack_i(irq_ack_i), .irq_o(irq_o), .debug_req_o(debug_req_o),
    .pc_core_id_i(pc_core_id_i), .tests_passed_o(tests_passed_o),
    .tests_failed_o(tests_failed_o), .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o)
  );

  always #5 clk_i = ~clk_i;

  // behavioural model state
  bit [31:0]   mem [int unsigned];
  logic          m_irv, m_drv, m_dread;
  logic [IW-1:0] m_ird;
  logic [31:0]   m_drd, m_irq, m_tcnt, m_tmask, m_exitval;
  logic          m_dbg, m_pass, m_fail, m_exitv;

  int n_checks = 0;
  int n_fail   = 0;
  int lit_id   = 0;
  bit chk_en   = 1'b0;

  function automatic logic [31:0] mem_rd(input int unsigned idx);
    return mem.exists(idx) ? mem[idx] : 32'd0;
  endfunction

  task automatic model_reset();
    m_irv = 0; m_drv = 0; m_dread = 0; m_ird = '0; m_drd = '0;
    m_irq = '0; m_tcnt = '0; m_tmask = '0; m_exitval = '0;
    m_dbg = 0; m_pass = 0; m_fail = 0; m_exitv = 0;
  endtask

  // One clock edge of the subsystem, evaluated from the documented rules.
  task automatic model_tick();
    logic [31:0] a, wd, ackm;
    int unsigned wi;
    bit ram, load, expire;
    if (!rst_ni) begin model_reset(); return; end
    m_irv = instr_req_i;
    if (instr_req_i) begin
      a = instr_addr_i % RAM_BYTES;
      for (int i = 0; i < 4; i++) m_ird[i*32 +: 32] = mem_rd((a / 16) * 4 + i);
    end
    ram     = data_addr_i < RAM_BYTES;
    wi      = data_addr_i / 4;
    m_drv   = data_req_i;
    m_dread = data_req_i && !data_we_i;
    if (m_dread) m_drd = ram ? mem_rd(wi) : 32'd0;
    ackm   = irq_ack_i ? (32'd1 << irq_id_i) : 32'd0;
    load   = data_req_i && data_we_i && (data_addr_i == 32'h1500_0004);
    expire = (m_tcnt == 1) && !load;
    m_irq  = (m_irq & ~ackm) | (expire ? m_tmask : 32'd0);
    if (load) m_tcnt = data_wdata_i;
    else if (m_tcnt != 0) m_tcnt = m_tcnt - 1;
    if (data_req_i && data_we_i) begin
      if (ram) begin
        wd = mem_rd(wi);
        for (int b = 0; b < 4; b++) if (data_be_i[b]) wd[b*8 +: 8] = data_wdata_i[b*8 +: 8];
        mem[wi] = wd;
      end else begin
        case (data_addr_i)
          32'h2000_0000: begin
            if (data_wdata_i == 123456789) m_pass = 1;
            if (data_wdata_i == 1) m_fail = 1;
          end
          32'h2000_0004: begin m_exitv = 1; m_exitval = data_wdata_i; end
          32'h1500_0000: m_tmask = data_wdata_i;
          32'h1500_0008: m_dbg = data_wdata_i[0];
          default: ;
        endcase
      end
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%0h expected=%0h", name, act, exp);
    end
  endtask

  // compare process: every mid-cycle, DUT versus model, plus directed literals
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("instr_gnt", instr_gnt_o, instr_req_i);
      check("data_gnt", data_gnt_o, data_req_i);
      check("instr_rvalid", instr_rvalid_o, m_irv);
      if (m_irv) check("instr_rdata", instr_rdata_o, m_ird);
      check("data_rvalid", data_rvalid_o, m_drv);
      if (m_drv && m_dread) check("data_rdata", data_rdata_o, m_drd);
      check("irq", irq_o, m_irq);
      check("debug_req", debug_req_o, m_dbg);
      check("passed", tests_passed_o, m_pass);
      check("failed", tests_failed_o, m_fail);
      check("exit_valid", exit_valid_o, m_exitv);
      check("exit_value", exit_value_o, m_exitval);
      case (lit_id)
        1: begin
          check("lit_rd_dead", {data_rvalid_o, data_rdata_o}, {1'b1, 32'hDEADBEEF});
          check("lit_if_dead", {instr_rvalid_o, instr_rdata_o[31:0]}, {1'b1, 32'hDEADBEEF});
        end
        3: check("lit_rd_be", data_rdata_o, 32'hDEADBEAA);
        4: check("lit_pass", {tests_passed_o, tests_failed_o}, 2'b10);
        5: check("lit_exit", {tests_passed_o, exit_valid_o, exit_value_o}, {2'b11, 32'h2A});
        6: check("lit_irq7", irq_o, 32'h80);
        7: check("lit_ack", irq_o, 32'h0);
        8: check("lit_dbg", {debug_req_o, irq_o[7]}, 2'b11);
        9: check("lit_rst", {debug_req_o, irq_o, instr_rvalid_o, data_rvalid_o}, 35'd0);
        10: check("lit_fail", {tests_passed_o, tests_failed_o}, 2'b01);
        default: ;
      endcase
    end
  end

  task automatic drive_idle();
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_addr_i = '0; data_be_i = '0; data_wdata_i = '0;
    irq_ack_i = 0; irq_id_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    model_tick();
    #1;
    lit_id = 0;
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    data_req_i = 1; data_we_i = 1; data_addr_i = a; data_wdata_i = d; data_be_i = be;
    step();
    drive_idle();
  endtask

  task automatic dread(input logic [31:0] a);
    data_req_i = 1; data_we_i = 0; data_addr_i = a; data_be_i = 4'hF;
    step();
    drive_idle();
  endtask

  task automatic rand_cycle();
    int r;
    drive_idle();
    instr_req_i  = ($urandom_range(0, 1) == 1);
    instr_addr_i = ($urandom() & 32'hFFF0_0000) | $urandom_range(0, 255);
    data_req_i   = ($urandom_range(0, 9) < 7);
    data_be_i    = 4'($urandom_range(0, 15));
    data_wdata_i = $urandom();
    r = $urandom_range(0, 99);
    if (r < 40) begin
      data_we_i = 0; data_addr_i = $urandom_range(0, 255);
    end else if (r < 70) begin
      data_we_i = 1; data_addr_i = $urandom_range(0, 255);
    end else if (r < 78) begin
      data_we_i = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: data_addr_i = 32'h0010_0000 + $urandom_range(0, 255);
        1: data_addr_i = 32'h3000_0000;
        2: data_addr_i = 32'h1500_000C;
        default: data_addr_i = 32'h2000_0008;
      endcase
    end else begin
      data_we_i = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 5))
        0: data_addr_i = 32'h1000_0000;
        1: begin
          data_addr_i = 32'h2000_0000;
          case ($urandom_range(0, 3))
            0: data_wdata_i = 123456789;
            1: data_wdata_i = 1;
            default: ;
          endcase
        end
        2: data_addr_i = 32'h2000_0004;
        3: data_addr_i = 32'h1500_0000;
        4: begin data_addr_i = 32'h1500_0004; data_wdata_i = $urandom_range(0, 8); end
        default: data_addr_i = 32'h1500_0008;
      endcase
    end
    irq_ack_i = ($urandom_range(0, 9) < 3);
    irq_id_i  = 5'($urandom_range(0, 31));
  endtask

  initial begin
    dm_halt_addr_i = 32'h1A11_0800;
    pc_core_id_i   = 32'h0000_0080;
    drive_idle();
    rst_ni = 0;
    model_reset();
    chk_en = 1;
    step(); step();
    rst_ni = 1;
    step();

    for (int w = 0; w < 64; w++) dwrite(w * 4, $urandom(), 4'hF);
    dwrite(32'h000F_FFFC, 32'h1234_5678, 4'hF);
    dread(32'h000F_FFFC);
    dread(32'h0010_0000);

    dwrite(32'h100, 32'hDEADBEEF, 4'hF);
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h100; data_be_i = 4'hF;
    instr_req_i = 1; instr_addr_i = 32'h100;
    step();
    drive_idle();
    lit_id = 1;
    step();

    dwrite(32'h100, 32'h0000_00AA, 4'h1);
    dread(32'h101);
    lit_id = 3;
    step();

    dwrite(32'h2000_0000, 123456789, 4'hF);
    lit_id = 4;
    step();
    dwrite(32'h2000_0004, 32'h2A, 4'hF);
    lit_id = 5;
    step();

    dwrite(32'h1500_0000, 32'h80, 4'hF);
    dwrite(32'h1500_0004, 32'd3, 4'hF);
    step(); step(); step();
    lit_id = 6;
    step();
    irq_ack_i = 1; irq_id_i = 5'd7;
    step();
    drive_idle();
    lit_id = 7;
    step();

    dwrite(32'h1500_0004, 32'd1, 4'hF);
    step();
    dwrite(32'h1500_0008, 32'd1, 4'hF);
    lit_id = 8;
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h104; data_be_i = 4'hF;
    instr_req_i = 1; instr_addr_i = 32'h110;
    step();
    rst_ni = 0;
    drive_idle();
    model_reset();
    lit_id = 9;
    step();
    rst_ni = 1;
    step();

    dwrite(32'h2000_0000, 32'd1, 4'hF);
    lit_id = 10;
    step();

    for (int c = 0; c < 3000; c++) begin
      rand_cycle();
      step();
    end

    drive_idle();
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
